dlx_wb_queue: RTL and testbench

- Write-back side producer for the DLX register file: collects results from the ALU and load/memory paths and drives the file's single write port (Rd, reg_s, reg_s_enable).
- Buffers results in a small in-order FIFO so a same-cycle ALU and load completion never loses a write.
- Exports a per-register pending-write vector for the decode-stage hazard logic.

---
 rtl/dlx_wb_queue_pkg.sv | 15 +
 rtl/dlx_wb_queue_if.sv | 30 +++
 rtl/dlx_wb_queue_fifo.sv | 64 ++++++
 rtl/dlx_wb_queue.sv | 86 ++++++++
 tb/tb_dlx_wb_queue.sv | 180 ++++++++++++++++++
 5 files changed

// File: rtl/dlx_wb_queue_pkg.sv
// Shared types and widths for the DLX write-back queue.
package dlx_wb_queue_pkg;

    localparam int unsigned REG_W    = 5;
    localparam int unsigned DATA_W   = 32;
    localparam int unsigned NUM_REGS = 1 << REG_W;

    typedef logic [REG_W-1:0] reg_idx_t;

    typedef struct packed {
        reg_idx_t          rd;
        logic [DATA_W-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/dlx_wb_queue_if.sv
// Producer handshakes plus the register-file write port and hazard outputs.
interface dlx_wb_queue_if;
    import dlx_wb_queue_pkg::*;

    logic                WB;
    logic                mem_valid;
    reg_idx_t            mem_rd;
    logic [DATA_W-1:0]   mem_data;
    logic                mem_ready;
    logic                alu_valid;
    reg_idx_t            alu_rd;
    logic [DATA_W-1:0]   alu_data;
    logic                alu_ready;
    reg_idx_t            Rd;
    logic [DATA_W-1:0]   reg_s;
    logic                reg_s_enable;
    logic [NUM_REGS-1:0] busy;
    logic                overflow;

    modport slave (
        input  WB, mem_valid, mem_rd, mem_data, alu_valid, alu_rd, alu_data,
        output mem_ready, alu_ready, Rd, reg_s, reg_s_enable, busy, overflow
    );

    modport master (
        output WB, mem_valid, mem_rd, mem_data, alu_valid, alu_rd, alu_data,
        input  mem_ready, alu_ready, Rd, reg_s, reg_s_enable, busy, overflow
    );

endinterface

// File: rtl/dlx_wb_queue_fifo.sv
// In-order FIFO of write-back entries: up to two ordered pushes, one pop per cycle.
module wb_fifo
    import dlx_wb_queue_pkg::*;
#(
    parameter  int unsigned DEPTH = 4,
    localparam int unsigned PW    = $clog2(DEPTH),
    localparam int unsigned CW    = PW + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_push0,
    input  wb_entry_t             i_data0,
    input  logic                  i_push1,
    input  wb_entry_t             i_data1,
    input  logic                  i_pop,
    output wb_entry_t             o_head,
    output logic [CW-1:0]         o_count,
    output wb_entry_t [DEPTH-1:0] o_entries,
    output logic [DEPTH-1:0]      o_occupied
);

    logic [PW-1:0] r_head;
    logic [PW-1:0] r_tail;
    logic [CW-1:0] r_count;
    wb_entry_t     r_mem [DEPTH];

    logic [PW-1:0] w_slot1;
    logic [CW-1:0] w_n_push;

    // Second push lands behind the first, or at the tail if it is alone.
    assign w_slot1  = i_push0 ? r_tail + PW'(1) : r_tail;
    assign w_n_push = CW'(i_push0) + CW'(i_push1);

    // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            r_tail  <= r_tail + PW'(w_n_push);
            r_head  <= r_head + PW'(i_pop);
            r_count <= r_count + w_n_push - CW'(i_pop);
        end
    end

    // Entry storage; contents need no reset since count gates validity.
    always_ff @(posedge clk) begin
        if (i_push0) r_mem[r_tail]  <= i_data0;
        if (i_push1) r_mem[w_slot1] <= i_data1;
    end

    assign o_head  = r_mem[r_head];
    assign o_count = r_count;

    // A slot is live when its distance from head is below the count.
    for (genvar g = 0; g < DEPTH; g++) begin : g_slot
        logic [PW-1:0] w_off;
        assign w_off         = PW'(g) - r_head;
        assign o_occupied[g] = CW'(w_off) < r_count;
        assign o_entries[g]  = r_mem[g];
    end

endmodule

// File: rtl/dlx_wb_queue.sv
// Write-back queue: merges ALU and load results into the register file write port.
module dlx_wb_queue
    import dlx_wb_queue_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input logic            clk,
    input logic            rst,
    dlx_wb_queue_if.slave  bus
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic [CW-1:0]         w_count;
    logic [CW-1:0]         w_free;
    logic                  w_mem_ready;
    logic                  w_alu_ready;
    logic                  w_mem_push;
    logic                  w_alu_push;
    logic                  w_pop;
    logic                  w_nonempty;
    logic                  w_violation;
    wb_entry_t             w_mem_entry;
    wb_entry_t             w_alu_entry;
    wb_entry_t             w_head;
    wb_entry_t [DEPTH-1:0] w_entries;
    logic [DEPTH-1:0]      w_occupied;
    logic [NUM_REGS-1:0]   w_busy;
    logic                  r_overflow;

    // Readiness counts only current occupancy; a same-cycle pop frees nothing.
    assign w_free      = CW'(DEPTH) - w_count;
    assign w_mem_ready = w_free >= CW'(1);
    assign w_alu_ready = (w_free >= CW'(2)) || ((w_free >= CW'(1)) && !bus.mem_valid);

    // r0 writes complete the handshake but are dropped before the FIFO.
    assign w_mem_push  = bus.mem_valid && w_mem_ready && (bus.mem_rd != '0);
    assign w_alu_push  = bus.alu_valid && w_alu_ready && (bus.alu_rd != '0);
    assign w_mem_entry = '{rd: bus.mem_rd, data: bus.mem_data};
    assign w_alu_entry = '{rd: bus.alu_rd, data: bus.alu_data};

    assign w_nonempty  = w_count != '0;
    assign w_pop       = bus.WB && w_nonempty && !rst;

    // Load is the older instruction, so it takes the first slot.
    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .i_push0    (w_mem_push),
        .i_data0    (w_mem_entry),
        .i_push1    (w_alu_push),
        .i_data1    (w_alu_entry),
        .i_pop      (w_pop),
        .o_head     (w_head),
        .o_count    (w_count),
        .o_entries  (w_entries),
        .o_occupied (w_occupied)
    );

    // Write port follows the head; a reset cycle issues no write.
    assign bus.mem_ready    = w_mem_ready;
    assign bus.alu_ready    = w_alu_ready;
    assign bus.reg_s_enable = w_nonempty && !rst;
    assign bus.Rd           = w_nonempty ? w_head.rd   : '0;
    assign bus.reg_s        = w_nonempty ? w_head.data : '0;

    // Pending-write vector for decode hazard checks; r0 never busy.
    always_comb begin
        w_busy = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            if (w_occupied[i]) w_busy[w_entries[i].rd] = 1'b1;
        end
        w_busy[0] = 1'b0;
    end
    assign bus.busy = w_busy;

    assign w_violation = (bus.mem_valid && !w_mem_ready) || (bus.alu_valid && !w_alu_ready);

    // Sticky record of any producer offering data while refused.
    always_ff @(posedge clk) begin
        if (rst)              r_overflow <= 1'b0;
        else if (w_violation) r_overflow <= 1'b1;
    end
    assign bus.overflow = r_overflow;

endmodule

// File: tb/tb_dlx_wb_queue.sv
// Scoreboard bench for dlx_wb_queue: directed plan followed by random traffic.
module tb_dlx_wb_queue;
    import dlx_wb_queue_pkg::*;

    localparam int unsigned DEPTH = 4;

    logic clk;
    logic rst;
    dlx_wb_queue_if bus();

    dlx_wb_queue #(.DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int        n_chk  = 0;
    int        n_pass = 0;
    wb_entry_t exp_q[$];   // reference contents of the queue as the DUT holds it now
    wb_entry_t pend_q[$];  // entries accepted at the coming edge
    bit        model_ovf  = 1'b0;
    bit        ovf_next   = 1'b0;
    bit        rst_prev   = 1'b0;
    bit        mon_en     = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [31:0] ref_busy();
        logic [31:0] b = '0;
        foreach (exp_q[i]) b[exp_q[i].rd] = 1'b1;
        b[0] = 1'b0;
        return b;
    endfunction

    // One clock of stimulus; model state advances with the edge that just passed.
    task automatic cycle(input bit r, input bit wb,
                         input bit mv, input reg_idx_t mrd, input logic [31:0] md,
                         input bit av, input reg_idx_t ard, input logic [31:0] ad);
        int free;
        bit er_m, er_a;
        @(posedge clk);
        #1;
        if (rst_prev) begin
            exp_q.delete();
            mon_en = 1'b1;
        end else begin
            while (pend_q.size() != 0) exp_q.push_back(pend_q.pop_front());
        end
        pend_q.delete();
        model_ovf = ovf_next;

        rst           = r;
        bus.WB        = wb;
        bus.mem_valid = mv;
        bus.mem_rd    = mrd;
        bus.mem_data  = md;
        bus.alu_valid = av;
        bus.alu_rd    = ard;
        bus.alu_data  = ad;

        free = int'(DEPTH) - exp_q.size();
        er_m = free >= 1;
        er_a = (free >= 2) || (free >= 1 && !mv);
        #1;
        if (mon_en) begin
            chk("mem_ready", 64'(bus.mem_ready), 64'(er_m));
            chk("alu_ready", 64'(bus.alu_ready), 64'(er_a));
        end
        if (r) begin
            ovf_next = 1'b0;
        end else begin
            if (mv && er_m && mrd != 0) pend_q.push_back('{rd: mrd, data: md});
            if (av && er_a && ard != 0) pend_q.push_back('{rd: ard, data: ad});
            ovf_next = model_ovf | (mv & ~er_m) | (av & ~er_a);
        end
        rst_prev = r;
    endtask

    task automatic idle(input bit wb);
        cycle(1'b0, wb, 1'b0, '0, '0, 1'b0, '0, '0);
    endtask

    // Monitor: at each negedge compare the write port and flags; pop on a committed write.
    initial begin
        wb_entry_t e;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                chk("overflow", 64'(bus.overflow), 64'(model_ovf));
                if (rst) begin
                    chk("enable_in_reset", 64'(bus.reg_s_enable), 64'(0));
                end else begin
                    chk("enable", 64'(bus.reg_s_enable), 64'(exp_q.size() != 0));
                    chk("busy", 64'(bus.busy), 64'(ref_busy()));
                    if (exp_q.size() == 0) begin
                        chk("rd_empty", 64'(bus.Rd), 64'(0));
                        chk("data_empty", 64'(bus.reg_s), 64'(0));
                    end else if (bus.WB) begin
                        e = exp_q.pop_front();
                        chk("write_rd", 64'(bus.Rd), 64'(e.rd));
                        chk("write_data", 64'(bus.reg_s), 64'(e.data));
                    end else begin
                        chk("head_rd", 64'(bus.Rd), 64'(exp_q[0].rd));
                        chk("head_data", 64'(bus.reg_s), 64'(exp_q[0].data));
                    end
                end
            end
        end
    end

    initial begin
        rst           = 1'b1;
        bus.WB        = 1'b0;
        bus.mem_valid = 1'b0;
        bus.mem_rd    = '0;
        bus.mem_data  = '0;
        bus.alu_valid = 1'b0;
        bus.alu_rd    = '0;
        bus.alu_data  = '0;

        // Reset state
        cycle(1, 0, 0, 0, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0, 0, 0, 0);
        idle(0);

        // Single ALU write held until WB
        cycle(0, 0, 0, 0, 0, 1, 5, 32'h1234);
        idle(0); idle(0); idle(0);
        idle(1);
        idle(0);

        // Dual completion to the same register, load first
        cycle(0, 1, 1, 3, 32'hAAAA, 1, 3, 32'h5555);
        idle(1); idle(1); idle(1);

        // r0 filter
        cycle(0, 0, 0, 0, 0, 1, 0, 32'hFFFF);
        idle(0);

        // Fill, back-pressure, overflow
        cycle(0, 0, 1, 1, 32'h11, 1, 2, 32'h22);
        cycle(0, 0, 1, 4, 32'h44, 1, 6, 32'h66);
        idle(0);
        idle(1);
        cycle(0, 0, 1, 7, 32'h77, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 1, 8, 32'h88);
        idle(0); idle(0);
        idle(1); idle(1); idle(1); idle(1); idle(0);

        // Reset mid-operation with WB high
        cycle(0, 0, 1, 10, 32'hA0, 1, 11, 32'hB0);
        cycle(0, 0, 0, 0, 0, 1, 12, 32'hC0);
        cycle(1, 1, 0, 0, 0, 0, 0, 0);
        idle(0);
        cycle(0, 0, 0, 0, 0, 1, 9, 32'hBEEF);
        idle(1);
        idle(0);

        // Random traffic
        for (int n = 0; n < 600; n++) begin
            cycle($urandom_range(0, 79) == 0, 1'($urandom_range(0, 1)),
                  $urandom_range(0, 2) != 0, reg_idx_t'($urandom_range(0, 7)), $urandom,
                  $urandom_range(0, 2) != 0, reg_idx_t'($urandom_range(0, 7)), $urandom);
        end
        for (int n = 0; n < 6; n++) idle(1);

        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
